noc_traffic_gen: RTL and testbench

//  Synthesizable, parametrised flit injector for an MESH_X x MESH_Y mesh; replaces hand-written per-port stimulus loops.
//  One instance per router local port drives flits over a 4-phase req/ack handshake with configurable gap, count and destination mode.

---
 rtl/noc_pkg.sv | 43 ++++
 rtl/lfsr16.sv | 19 +
 rtl/noc_traffic_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh flit injector.
package noc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_REQ,
        ST_REL,
        ST_DONE
    } tg_state_e;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_SWEEP  = 2'd1,
        MODE_RANDOM = 2'd2,
        MODE_RSVD   = 2'd3
    } tg_mode_e;

    // Node-id width; a single-node mesh still needs one id bit.
    function automatic int unsigned id_width(input int unsigned nodes);
        return (nodes <= 1) ? 1 : $clog2(nodes);
    endfunction

    // Packs {dest, src, seq} into the low id_w+id_w+seq_w bits of a wide word.
    function automatic logic [127:0] pack_flit(
        input logic [127:0] dest,
        input logic [127:0] src,
        input logic [127:0] seq,
        input int unsigned  id_w,
        input int unsigned  seq_w
    );
        logic [127:0] ones;
        logic [127:0] id_mask;
        logic [127:0] seq_mask;
        ones     = '1;
        id_mask  = ~(ones << id_w);
        seq_mask = ~(ones << seq_w);
        return ((dest & id_mask) << (id_w + seq_w)) |
               ((src & id_mask) << seq_w) |
               (seq & seq_mask);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping only when enabled.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    // Shift left, feedback into bit 0.
    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else if (en)
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/noc_traffic_gen.sv
// Flit injector for one router local port: 4-phase req/ack, gap/count/dest modes.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MESH_X    = 2,
    parameter int unsigned MESH_Y    = 2,
    parameter int unsigned GAP_W     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned NODES    = MESH_X * MESH_Y,
    localparam int unsigned ID_W     = id_width(NODES),
    localparam int unsigned SEQ_W    = DATA_W - 2 * ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [ID_W-1:0]   src_id,
    input  logic [ID_W-1:0]   cfg_dest,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [CNT_W-1:0]  num_flits,
    input  logic [SEQ_W-1:0]  seq_base,
    output logic [DATA_W-1:0] out_data,
    output logic              out_req,
    input  logic              in_ack,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    function automatic logic [ID_W-1:0] wrap_id(input logic [31:0] v);
        return ID_W'(v % NODES);
    endfunction

    tg_state_e         state, state_n;
    tg_mode_e          mode_r, mode_n;
    logic [ID_W-1:0]   src_r, src_n;
    logic [GAP_W-1:0]  gap_r, gap_n;
    logic [CNT_W-1:0]  num_r, num_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [SEQ_W-1:0]  seq, seq_n;
    logic [ID_W-1:0]   cur_dest, cur_dest_n;
    logic [ID_W-1:0]   last_dest, last_dest_n;
    logic              stop_seen, stop_seen_n;
    logic [DATA_W-1:0] data_n;
    logic              req_n, busy_n, done_n, tmo_n;
    logic [CNT_W-1:0]  sent_n, sent_inc;
    logic [ID_W-1:0]   dest_pick, dest_base;
    logic              launch;
    logic [15:0]       lfsr_q;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (launch),
        .q   (lfsr_q)
    );

    // Destination for the next flit; SWEEP/RANDOM never target the own node.
    always_comb begin
        dest_base = (mode_r == MODE_RANDOM) ? wrap_id(32'(lfsr_q)) : cur_dest;
        dest_pick = dest_base;
        if (mode_r == MODE_SWEEP || mode_r == MODE_RANDOM) begin
            if (NODES == 1)
                dest_pick = src_r;
            else if (dest_base == src_r)
                dest_pick = wrap_id(32'(src_r) + 32'd1);
        end
    end

    // Next-state and datapath update for the handshake FSM.
    always_comb begin
        state_n     = state;
        mode_n      = mode_r;
        src_n       = src_r;
        gap_n       = gap_r;
        num_n       = num_r;
        gap_cnt_n   = gap_cnt;
        wait_n      = wait_cnt;
        seq_n       = seq;
        cur_dest_n  = cur_dest;
        last_dest_n = last_dest;
        stop_seen_n = stop_seen;
        data_n      = out_data;
        req_n       = out_req;
        busy_n      = busy;
        done_n      = done;
        tmo_n       = timeout;
        sent_n      = sent_cnt;
        launch      = 1'b0;
        sent_inc    = (&sent_cnt) ? sent_cnt : sent_cnt + CNT_W'(1);

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_n      = tg_mode_e'(mode);
                    src_n       = src_id;
                    gap_n       = gap_cycles;
                    num_n       = num_flits;
                    seq_n       = seq_base;
                    cur_dest_n  = wrap_id(32'(cfg_dest));
                    stop_seen_n = 1'b0;
                    done_n      = 1'b0;
                    tmo_n       = 1'b0;
                    sent_n      = '0;
                    busy_n      = 1'b1;
                    gap_cnt_n   = gap_cycles;
                    state_n     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else if (gap_cnt == '0) begin
                    launch      = 1'b1;
                    data_n      = DATA_W'(pack_flit(128'(dest_pick), 128'(src_r),
                                                    128'(seq), ID_W, SEQ_W));
                    req_n       = 1'b1;
                    wait_n      = '0;
                    last_dest_n = dest_pick;
                    state_n     = ST_REQ;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
            end
            ST_REQ: begin
                if (stop)
                    stop_seen_n = 1'b1;
                if (in_ack) begin
                    req_n   = 1'b0;
                    wait_n  = '0;
                    state_n = ST_REL;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    req_n   = 1'b0;
                    tmo_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            ST_REL: begin
                if (stop)
                    stop_seen_n = 1'b1;
                if (!in_ack) begin
                    sent_n = sent_inc;
                    seq_n  = seq + SEQ_W'(1);
                    if (mode_r == MODE_SWEEP)
                        cur_dest_n = wrap_id(32'(last_dest) + 32'd1);
                    // A stop arriving in this very cycle still ends the run here.
                    if (stop_seen || stop || (num_r != '0 && sent_inc == num_r)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        gap_cnt_n = gap_r;
                        state_n   = ST_GAP;
                    end
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    tmo_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_FIXED;
            src_r     <= '0;
            gap_r     <= '0;
            num_r     <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            seq       <= '0;
            cur_dest  <= '0;
            last_dest <= '0;
            stop_seen <= 1'b0;
            out_data  <= '0;
            out_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            sent_cnt  <= '0;
        end else begin
            state     <= state_n;
            mode_r    <= mode_n;
            src_r     <= src_n;
            gap_r     <= gap_n;
            num_r     <= num_n;
            gap_cnt   <= gap_cnt_n;
            wait_cnt  <= wait_n;
            seq       <= seq_n;
            cur_dest  <= cur_dest_n;
            last_dest <= last_dest_n;
            stop_seen <= stop_seen_n;
            out_data  <= data_n;
            out_req   <= req_n;
            busy      <= busy_n;
            done      <= done_n;
            timeout   <= tmo_n;
            sent_cnt  <= sent_n;
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen on a 2x2 mesh with a flit scoreboard.
module tb_noc_traffic_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [1:0]  mode, src_id, cfg_dest;
    logic [7:0]  gap_cycles;
    logic [15:0] num_flits;
    logic [27:0] seq_base;
    logic [31:0] out_data;
    logic        out_req;
    logic        in_ack = 1'b0;
    logic        busy, done, timeout;
    logic [15:0] sent_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          ack_mode = 0;
    logic [31:0] sb[$];
    logic        req_q = 1'b0;
    bit          t3_active = 1'b0;
    logic [3:0]  seen = '0;
    int          collisions = 0;

    always #5 clk = ~clk;

    noc_traffic_gen #(
        .DATA_W   (32),
        .MESH_X   (2),
        .MESH_Y   (2),
        .GAP_W    (8),
        .CNT_W    (16),
        .TIMEOUT  (16),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .src_id    (src_id),
        .cfg_dest  (cfg_dest),
        .gap_cycles(gap_cycles),
        .num_flits (num_flits),
        .seq_base  (seq_base),
        .out_data  (out_data),
        .out_req   (out_req),
        .in_ack    (in_ack),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .sent_cnt  (sent_cnt)
    );

    // Router stand-in: acknowledge echoes request one cycle later, or stays low.
    always @(posedge clk) in_ack <= (ack_mode == 0) ? out_req : 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flit(input logic [1:0] d, input logic [1:0] s,
                                         input logic [27:0] q);
        return {d, s, q};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Every rising request must match the oldest expected flit.
    always @(negedge clk) begin
        if (out_req && !req_q) begin
            if (sb.size() == 0) begin
                check("req_without_expected_flit", 64'(sb.size()), 64'd1);
            end else begin
                check("flit", 64'(out_data), 64'(sb.pop_front()));
                if (t3_active) begin
                    seen[out_data[31:30]] = 1'b1;
                    if (out_data[31:30] == out_data[29:28]) collisions++;
                end
            end
        end
        req_q = out_req;
    end

    task automatic cfg_start(input logic [1:0] m, input logic [1:0] s, input logic [1:0] d,
                             input logic [7:0] g, input logic [15:0] n, input logic [27:0] q,
                             input logic with_stop);
        @(negedge clk);
        mode = m; src_id = s; cfg_dest = d; gap_cycles = g; num_flits = n; seq_base = q;
        start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_req_rise(input int budget, input string tag);
        int n = 0;
        while (out_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        while (!out_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(out_req), 64'd1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] lm;
        int          hc;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = '0; src_id = '0; cfg_dest = '0; gap_cycles = '0; num_flits = '0; seq_base = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_req", 64'(out_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_sent_cnt", 64'(sent_cnt), 64'd0);

        // T1: FIXED, dest 3, back-to-back, three flits
        sb.push_back(32'hC000_0227);
        sb.push_back(32'hC000_0228);
        sb.push_back(32'hC000_0229);
        cfg_start(2'd0, 2'd0, 2'd3, 8'd0, 16'd3, 28'h227, 1'b0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(200, "t1_done");
        check("t1_sent_cnt", 64'(sent_cnt), 64'd3);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_hold_data", 64'(out_data), 64'hC000_0229);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // T2: SWEEP from 0 with src 1, start and stop together (start wins)
        sb.push_back(flit(2'd0, 2'd1, 28'h10));
        sb.push_back(flit(2'd2, 2'd1, 28'h11));
        sb.push_back(flit(2'd3, 2'd1, 28'h12));
        sb.push_back(flit(2'd0, 2'd1, 28'h13));
        cfg_start(2'd1, 2'd1, 2'd0, 8'd1, 16'd4, 28'h10, 1'b1);
        check("t2_done_cleared", 64'(done), 64'd0);
        wait_done(300, "t2_done");
        check("t2_sent_cnt", 64'(sent_cnt), 64'd4);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // T4: ack never arrives; request held for 16 cycles then abort
        ack_mode = 1;
        sb.push_back(flit(2'd2, 2'd0, 28'h0));
        cfg_start(2'd0, 2'd0, 2'd2, 8'd0, 16'd5, 28'h0, 1'b0);
        wait_req_rise(50, "t4_req_rise");
        hc = 0;
        while (out_req && hc < 100) begin
            hc++;
            @(negedge clk);
        end
        check("t4_req_high_cycles", 64'(hc), 64'd16);
        check("t4_timeout", 64'(timeout), 64'd1);
        check("t4_done", 64'(done), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_sent_cnt", 64'(sent_cnt), 64'd0);
        ack_mode = 0;
        repeat (2) @(negedge clk);

        // T5: unbounded run, gap 2, stop during second REQ
        sb.push_back(flit(2'd3, 2'd2, 28'h500));
        sb.push_back(flit(2'd3, 2'd2, 28'h501));
        cfg_start(2'd0, 2'd2, 2'd3, 8'd2, 16'd0, 28'h500, 1'b0);
        check("t5_timeout_cleared", 64'(timeout), 64'd0);
        wait_req_rise(50, "t5_req1");
        wait_req_rise(50, "t5_req2");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_req_held", 64'(out_req), 64'd1);
        wait_done(50, "t5_done");
        repeat (20) @(negedge clk);
        check("t5_no_more_req", 64'(out_req), 64'd0);
        check("t5_sent_cnt", 64'(sent_cnt), 64'd2);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

        // T6: reset mid-REQ with ack high, then rerun T1
        sb.push_back(32'hC000_0227);
        sb.push_back(32'hC000_0228);
        sb.push_back(32'hC000_0229);
        cfg_start(2'd0, 2'd0, 2'd3, 8'd0, 16'd3, 28'h227, 1'b0);
        wait_req_rise(50, "t6_req_rise");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_req_dropped", 64'(out_req), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_sent_cnt", 64'(sent_cnt), 64'd0);
        check("t6_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        sb.push_back(32'hC000_0227);
        sb.push_back(32'hC000_0228);
        sb.push_back(32'hC000_0229);
        cfg_start(2'd0, 2'd0, 2'd3, 8'd0, 16'd3, 28'h227, 1'b0);
        wait_done(200, "t6_rerun_done");
        check("t6_rerun_sent", 64'(sent_cnt), 64'd3);
        check("t6_rerun_data", 64'(out_data), 64'hC000_0229);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        // T3: RANDOM, 1000 flits from a fresh LFSR, seq wraps mid-run
        pulse_rst();
        lm = 16'hACE1;
        for (int i = 0; i < 1000; i++) begin
            logic [1:0]  d;
            logic [27:0] q;
            d = lm[1:0];
            if (d == 2'd2) d = 2'd3;
            q = 28'hFFF_FE00 + 28'(i);
            sb.push_back(flit(d, 2'd2, q));
            lm = lfsr_step(lm);
        end
        t3_active = 1'b1;
        cfg_start(2'd2, 2'd2, 2'd0, 8'd0, 16'd1000, 28'hFFF_FE00, 1'b0);
        wait_done(8000, "t3_done");
        t3_active = 1'b0;
        check("t3_sent_cnt", 64'(sent_cnt), 64'd1000);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);
        check("t3_dests_seen", 64'(seen), 64'hB);
        check("t3_dest_eq_src", 64'(collisions), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
